fetch_queue_unit: RTL

Parametrised instruction-fetch front end for the pipelined RISC-V core. It sits between the PC logic and the IF/ID register. It issues in-order fetch requests to the instruction memory/cache over a valid/ready handshake that tolerates variable latency. Returned words are buffered in a DEPTH-entry FIFO tagged with their PC. Redirects from the execute stage (branch, jal, jalr) are handled by flushing the queue and discarding stale in-flight responses, replacing the fixed single-cycle stall/forward muxing of the earlier fetch path.

---
 rtl/fetch_queue_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction-fetch front end. It sits between the PC logic and the IF/ID
// register and issues in-order fetch requests over a valid/ready handshake.
// Returned words are queued together with their PC. A redirect from execute
// flushes the queue, and responses still in flight at that point are
// discarded as they arrive.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   redirect_valid/_pc       execute-stage redirect (branch, jal, jalr)
//   imem_req_valid/_addr     fetch request to instruction memory
//   imem_req_ready           memory accepts the request
//   imem_rsp_valid/_data     in-order response word (no backpressure)
//   deq_valid/_instr/_pc     head entry presented to decode
//   deq_pcplus               head PC + PC_STEP
//   deq_ready                decode consumes the head entry
//
// Build option
//   FETCHQ_BYPASS_EN  when defined, an undropped response that arrives while
//                     the queue is empty is shown on deq_* in the same cycle.
//                     When undefined, every word goes through the queue and
//                     no combinational path runs from imem_rsp_* to deq_*.
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            deq_valid,
    output logic [XLEN-1:0] deq_instr,
    output logic [XLEN-1:0] deq_pc,
    output logic [XLEN-1:0] deq_pcplus,
    input  logic            deq_ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // The drop counter is one bit wider than the credit counters. Back-to-back
    // redirects can stack a fresh batch of outstanding requests on top of
    // drops that are still pending.
    localparam int unsigned DW = CW + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   ord_ptr_q, ord_ptr_d, owr_ptr_q, owr_ptr_d;
    logic [CW-1:0]   count_q, count_d, outst_q, outst_d;
    logic [DW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] opc_q   [DEPTH];   // PCs of outstanding requests

    logic req_fire, rsp_drop, rsp_take, byp, push, pop;
    logic [XLEN-1:0] head_instr, head_pc;
    logic [DW-1:0]   occ;

    assign occ            = DW'(count_q) + DW'(outst_q);
    assign imem_req_valid = rst && !redirect_valid && (occ < DW'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding and nothing to drop is a protocol
    // error. It matches neither term and is ignored.
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_take = imem_rsp_valid && (drop_q == '0) && (outst_q != '0);

`ifdef FETCHQ_BYPASS_EN
    assign byp        = rsp_take && (count_q == '0) && !redirect_valid;
    assign head_instr = byp ? imem_rsp_data     : instr_q[rd_ptr_q];
    assign head_pc    = byp ? opc_q[ord_ptr_q]  : pc_q[rd_ptr_q];
`else
    assign byp        = 1'b0;
    assign head_instr = instr_q[rd_ptr_q];
    assign head_pc    = pc_q[rd_ptr_q];
`endif

    assign deq_valid  = !redirect_valid && ((count_q != '0) || byp);
    assign deq_instr  = deq_valid ? head_instr : '0;
    assign deq_pc     = deq_valid ? head_pc : '0;
    assign deq_pcplus = deq_valid ? head_pc + STEP : '0;

    // A bypassed word that decode takes right away is never written.
    assign pop  = deq_valid && deq_ready && !byp;
    assign push = rsp_take && !redirect_valid && !(byp && deq_ready);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        ord_ptr_d  = ord_ptr_q;
        owr_ptr_d  = owr_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            ord_ptr_d  = '0;
            owr_ptr_d  = '0;
            count_d    = '0;
            outst_d    = '0;
            // A response arriving now settles one of the pending drops.
            drop_d     = drop_q + DW'(outst_q)
                         - DW'(rsp_drop || (imem_rsp_valid && outst_q != '0));
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + STEP;
                owr_ptr_d  = owr_ptr_q + AW'(1);
            end
            if (rsp_take) ord_ptr_d = ord_ptr_q + AW'(1);
            if (rsp_drop) drop_d = drop_q - DW'(1);
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            outst_d = outst_q + CW'(req_fire) - CW'(rsp_take);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            ord_ptr_q  <= '0;
            owr_ptr_q  <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            ord_ptr_q  <= ord_ptr_d;
            owr_ptr_q  <= owr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // Storage is not reset. Reads are qualified by count/outstanding.
    always_ff @(posedge clk) begin
        if (req_fire) opc_q[owr_ptr_q] <= fetch_pc_q;
        if (push) begin
            instr_q[wr_ptr_q] <= imem_rsp_data;
            pc_q[wr_ptr_q]    <= opc_q[ord_ptr_q];
        end
    end
endmodule
